// File: rtl/fifo_pkg.sv
// Shared constants for the sync_fifo_pro family.
package fifo_pkg;
   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;
endpackage

// File: rtl/sync_fifo_pro_if.sv
// Producer/consumer-side bundle of sync_fifo_pro; master drives requests, slave is the FIFO.
interface sync_fifo_pro_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) ();
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic                  clr;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   af_thresh;
   logic [ADDR_WIDTH:0]   ae_thresh;
   logic [ADDR_WIDTH:0]   data_count;
   logic                  overflow;
   logic                  underflow;
   logic                  err_clr;

   modport master (
      output clr, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             data_count, overflow, underflow
   );

   modport slave (
      input  clr, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             data_count, overflow, underflow
   );
endinterface

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: synchronous write, asynchronous read. Contents are never reset.
module fifo_mem_2p #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                          clk,
   input  logic                          i_wr_en,
   input  logic [$clog2(DEPTH)-1:0]      i_wr_addr,
   input  logic [DATA_WIDTH-1:0]         i_wr_data,
   input  logic [$clog2(DEPTH)-1:0]      i_rd_addr,
   output logic [DATA_WIDTH-1:0]         o_rd_data
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Write port
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/sync_fifo_pro.sv
// Parametrised single-clock FIFO with STD/FWFT read modes, thresholds, flush and sticky errors.
module sync_fifo_pro
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int FWFT       = FIFO_MODE_STD
) (
   input  logic           clk,
   input  logic           rst,
   sync_fifo_pro_if.slave bus
);
   localparam int                    ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0]   C_DEPTH    = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   C_CNT_ZERO = (ADDR_WIDTH+1)'(0);
   localparam logic [ADDR_WIDTH:0]   C_CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] C_PTR_ZERO = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE  = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic                  w_mem_we;
   logic [DATA_WIDTH-1:0] w_mem_rd_data;

   assign w_full   = (r_count == C_DEPTH);
   assign w_empty  = (r_count == C_CNT_ZERO);
   assign w_rd_acc = bus.rd_en && !w_empty;
   // A full FIFO still takes a write when a pop frees a slot on the same edge.
   assign w_wr_acc = bus.wr_en && (!w_full || w_rd_acc);
   assign w_mem_we = w_wr_acc && !bus.clr;

   fifo_mem_2p #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_mem_we),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (bus.wr_data),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_mem_rd_data)
   );

   // Pointers and occupancy; clr empties the FIFO and drops same-cycle accesses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= C_PTR_ZERO;
         r_rd_ptr <= C_PTR_ZERO;
         r_count  <= C_CNT_ZERO;
      end else if (bus.clr) begin
         r_wr_ptr <= C_PTR_ZERO;
         r_rd_ptr <= C_PTR_ZERO;
         r_count  <= C_CNT_ZERO;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky error flags; a set event beats err_clr on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (bus.clr) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (bus.wr_en && !w_wr_acc) r_overflow <= 1'b1;
         else if (bus.err_clr)       r_overflow <= 1'b0;
         if (bus.rd_en && w_empty)   r_underflow <= 1'b1;
         else if (bus.err_clr)       r_underflow <= 1'b0;
      end
   end

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         assign bus.rd_data  = w_mem_rd_data;
         assign bus.rd_valid = !w_empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_rd_data;
         logic                  r_rd_valid;

         // Registered read: data one cycle after the pop, valid for that cycle only.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_rd_data  <= {DATA_WIDTH{1'b0}};
               r_rd_valid <= 1'b0;
            end else if (bus.clr) begin
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_rd_acc;
               if (w_rd_acc) r_rd_data <= w_mem_rd_data;
            end
         end

         assign bus.rd_data  = r_rd_data;
         assign bus.rd_valid = r_rd_valid;
      end
   endgenerate

   assign bus.full         = w_full;
   assign bus.empty        = w_empty;
   assign bus.data_count   = r_count;
   assign bus.almost_full  = (r_count >= bus.af_thresh);
   assign bus.almost_empty = (r_count <= bus.ae_thresh);
   assign bus.overflow     = r_overflow;
   assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_pro.sv
// Scoreboard bench: one STD and one FWFT instance driven identically against a queue model.
module tb_sync_fifo_pro;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sync_fifo_pro_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) s_if ();
   sync_fifo_pro_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) f_if ();

   sync_fifo_pro #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
      .clk (clk), .rst (rst), .bus (s_if)
   );
   sync_fifo_pro #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
      .clk (clk), .rst (rst), .bus (f_if)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_s[$];
   logic [DW-1:0] exp_f[$];
   bit            m_ovf, m_unf, m_rdv;
   logic [DW-1:0] m_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit wr, input logic [DW-1:0] d, input bit rd, input bit cl, input bit ec);
      s_if.wr_en = wr; s_if.wr_data = d; s_if.rd_en = rd; s_if.clr = cl; s_if.err_clr = ec;
      f_if.wr_en = wr; f_if.wr_data = d; f_if.rd_en = rd; f_if.clr = cl; f_if.err_clr = ec;
   endtask

   task automatic model_reset();
      mq.delete(); exp_s.delete(); exp_f.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_rdv = 1'b0; m_last = '0;
   endtask

   task automatic check_state();
      int n;
      n = mq.size();
      chk("s_count", s_if.data_count, n);
      chk("f_count", f_if.data_count, n);
      chk("s_full", s_if.full, n == DEPTH);
      chk("s_empty", s_if.empty, n == 0);
      chk("f_empty", f_if.empty, n == 0);
      chk("s_almost_full", s_if.almost_full, n >= AF);
      chk("s_almost_empty", s_if.almost_empty, n <= AE);
      chk("s_overflow", s_if.overflow, m_ovf);
      chk("s_underflow", s_if.underflow, m_unf);
      chk("f_overflow", f_if.overflow, m_ovf);
      chk("f_underflow", f_if.underflow, m_unf);
      chk("s_rd_valid", s_if.rd_valid, m_rdv);
      chk("s_rd_data_hold", s_if.rd_data, m_last);
      chk("f_rd_valid", f_if.rd_valid, n != 0);
      if (n != 0) chk("f_head", f_if.rd_data, mq[0]);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_s_count"}, s_if.data_count, 0);
      chk({tag, "_s_empty"}, s_if.empty, 1);
      chk({tag, "_s_full"}, s_if.full, 0);
      chk({tag, "_s_rd_valid"}, s_if.rd_valid, 0);
      chk({tag, "_s_rd_data"}, s_if.rd_data, 0);
      chk({tag, "_s_overflow"}, s_if.overflow, 0);
      chk({tag, "_s_underflow"}, s_if.underflow, 0);
      chk({tag, "_f_rd_valid"}, f_if.rd_valid, 0);
      chk({tag, "_f_count"}, f_if.data_count, 0);
   endtask

   // One clock of stimulus: update the model from the rules, apply, then check outputs.
   task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd, input bit cl, input bit ec);
      bit rd_acc, wr_acc;
      logic [DW-1:0] v;
      drive(wr, d, rd, cl, ec);
      m_rdv = 1'b0;
      if (cl) begin
         mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         rd_acc = rd && (mq.size() != 0);
         wr_acc = wr && ((mq.size() < DEPTH) || rd_acc);
         if (wr && !wr_acc) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
         if (rd && mq.size() == 0) m_unf = 1'b1; else if (ec) m_unf = 1'b0;
         if (rd_acc) begin
            v = mq.pop_front();
            exp_s.push_back(v); exp_f.push_back(v);
            m_last = v; m_rdv = 1'b1;
         end
         if (wr_acc) mq.push_back(d);
      end
      @(posedge clk); #1;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check_state();
   endtask

   // Monitor: STD data arrives on rd_valid; FWFT data is consumed when popped.
   always @(negedge clk) begin
      if (rst === 1'b0 && s_if.rd_valid === 1'b1) begin
         if (exp_s.size() == 0) chk("std_unexpected_valid", 1, 0);
         else chk("std_rd_data", s_if.rd_data, exp_s.pop_front());
      end
      if (rst === 1'b0 && f_if.rd_valid === 1'b1 && f_if.rd_en === 1'b1 && f_if.clr === 1'b0) begin
         if (exp_f.size() == 0) chk("fwft_unexpected_pop", 1, 0);
         else chk("fwft_rd_data", f_if.rd_data, exp_f.pop_front());
      end
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      s_if.af_thresh = 5'(AF); s_if.ae_thresh = 5'(AE);
      f_if.af_thresh = 5'(AF); f_if.ae_thresh = 5'(AE);
      model_reset();
      @(posedge clk); #1;
      check_reset("por");
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Fill to full, then one write too many.
      for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      // Drain, then one read too many.
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("underflow_hold_data", s_if.rd_data, 8'h10);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

      // Write while full with a simultaneous read.
      for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Set event and err_clr on the same edge: set wins.
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // FWFT fall-through of a single word.
      step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      chk("fwft_fallthrough", f_if.rd_data, 8'h5A);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Random interleaved traffic with occupancy kept within 3..13.
      for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         bit wr, rd;
         wr = 1'($urandom_range(0, 1));
         rd = 1'($urandom_range(0, 1));
         if (mq.size() >= 13) wr = 1'b0;
         if (mq.size() <= 3)  rd = 1'b0;
         step(wr, 8'($urandom_range(0, 255)), rd, 1'b0, 1'b0);
      end

      // Flush at count 7 with a write and read pending.
      while (mq.size() > 7) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      while (mq.size() < 7) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset between edges, with a read in flight.
      #2 rst = 1'b1;
      #1;
      check_reset("mid_rst");
      model_reset();
      #1 rst = 1'b0;
      @(posedge clk); #1;
      step(1'b1, 8'h9C, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h3D, 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      @(negedge clk); #1;
      chk("std_scoreboard_drained", exp_s.size(), 0);
      chk("fwft_scoreboard_drained", exp_f.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sync_fifo_pro.md
Name: sync_fifo_pro

Overview:
Parametrised synchronous FIFO for single-clock datapaths, the next generation of the team's basic 8x16 FIFO. Adds generalised width/depth, a compile-time read mode (standard registered read or first-word-fall-through), programmable almost-full/almost-empty thresholds, a synchronous flush, sticky overflow/underflow error flags, and write-when-full acceptance if a read is accepted in the same cycle. It sits between producer and consumer stages wherever rate decoupling is needed.

Parameters:
DATA_WIDTH, 8, width of each data word.
DEPTH, 16, number of entries; power of two, at least 2.
ADDR_WIDTH, $clog2(DEPTH), pointer width; derived, never overridden.
FWFT, 0, read mode: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
clr  in  1  synchronous flush; empties the FIFO.
wr_en  in  1  write request.
wr_data  in  DATA_WIDTH  write data.
rd_en  in  1  read/pop request.
rd_data  out  DATA_WIDTH  read data.
rd_valid  out  1  rd_data holds valid data (see Behaviour).
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= af_thresh.
almost_empty  out  1  count <= ae_thresh.
af_thresh  in  ADDR_WIDTH+1  almost-full threshold; quasi-static.
ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold; quasi-static.
data_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  out  1  sticky: a write was dropped.
underflow  out  1  sticky: a read was made when empty.
err_clr  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset: clk and rst as decided above; rst is asynchronous and active-high. On rst, pointers = 0, count = 0, rd_data = 0, rd_valid = 0 (STD mode), overflow = 0, underflow = 0. Outputs go to these values immediately, without waiting for a clock edge. Memory contents are not reset.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc).
- A write into an empty FIFO is not readable in the same cycle.
- Count update: +1 on write only; -1 on read only; unchanged on both or neither. Pointers wrap modulo DEPTH with natural ADDR_WIDTH overflow.
- STD mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid = 1 on the next cycle, for one cycle only.
  - Latency is 1 cycle. rd_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] through a combinational read; rd_valid = !empty.
  - rd_en acts as a pop. The head word is visible one cycle after the write that fills an empty FIFO.
- almost_full and almost_empty are combinational from the count register. A threshold outside 0..DEPTH is the integrator's error; no checking.
- overflow is set when wr_en && !wr_acc. underflow is set when rd_en && empty.
- Both error flags stay set until err_clr, clr, or rst. A set event in the same cycle as err_clr wins (the flag stays 1).
- clr: next edge sets pointers = 0, count = 0, rd_valid = 0 and clears the error flags; rd_data is unchanged.
  - clr has priority over wr_en and rd_en in the same cycle; those accesses are dropped without setting the error flags.
- rst mid-operation takes effect immediately; any in-flight read is lost.

Decomposition:
- Shared package fifo_pkg: FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1 constants, plus a clog2 helper if the toolflow needs one.
- One sub-module, fifo_mem_2p: DATA_WIDTH x DEPTH memory with synchronous write and asynchronous read port. STD mode registers its output in the top level.
- Pointer, count, flag, and error logic stay in the top level.

Test Plan:
1. DEPTH=16, af_thresh=14, after rst: write 0x01..0x10 -> almost_full rises when count reaches 14; full=1 and data_count=16 after the 16th write. A 17th write (0xEE) -> overflow=1, count stays 16, 0xEE never read.
2. STD mode, drain after test 1: each rd_en -> rd_valid=1 next cycle with rd_data = 0x01..0x10 in order; empty=1 after 16 reads. An extra rd_en -> underflow=1, rd_valid=0, rd_data holds 0x10.
3. Full FIFO (0x01..0x10), wr_en=1 with wr_data=0xAA and rd_en=1 in the same cycle -> read returns 0x01, write accepted, count stays 16, overflow=0. Drain yields 0x02..0x10 then 0xAA.
4. FWFT=1, empty: write 0x5A -> next cycle rd_valid=1 and rd_data=0x5A with no rd_en. A rd_en pulse -> empty=1 and rd_valid=0 the following cycle.
5. Wrap-around: 40 cycles of random interleaved push/pop at count 3..13 -> scoreboard matches exactly; data_count tracks the model each cycle; pointers wrap past 15.
6. At count=7, assert clr with wr_en=1 -> next cycle count=0, empty=1, write dropped, overflow=0. Refill 3 words, then assert rst between clock edges -> all outputs at reset values before the next edge.
